// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load, logical/arithmetic/rotate shifts,
// single-step serial streaming and a multi-position shift sequencer that
// reports progress through a busy/done handshake.
module universal_shift_register #(
  parameter int N     = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [N-1:0]     data_in,
  input  logic             start,
  input  logic             step,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  input  logic             direction,
  input  logic             serial_in,
  output logic [N-1:0]     D,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       lat_mode;
  logic             lat_dir;
  logic             eff_dir;

  // One-position shift of v; the fill bit depends on the mode
  // (mode 11 is treated as logical).
  function automatic logic [N-1:0] shift_one(
    input logic [N-1:0] v,
    input logic [1:0]   m,
    input logic         dir,
    input logic         sin
  );
    logic fill;
    case (m)
      2'b01:   fill = dir ? v[N-1] : 1'b0;
      2'b10:   fill = dir ? v[0] : v[N-1];
      default: fill = sin;
    endcase
    shift_one = dir ? {fill, v[N-1:1]} : {v[N-2:0], fill};
  endfunction

  // State register; reset aborts any sequence in flight without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: load outranks start, and SHIFT/DONE ignore all requests.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!load && start) begin
          next_state = (amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == AMT_W'(1)) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: register contents, remaining count and latched shift controls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      D        <= '0;
      cnt      <= '0;
      lat_mode <= 2'b00;
      lat_dir  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            D <= data_in;
          end else if (start) begin
            lat_mode <= mode;
            lat_dir  <= direction;
            cnt      <= amount;
          end else if (step) begin
            D <= shift_one(D, mode, direction, serial_in);
          end
        end
        SHIFT: begin
          D   <= shift_one(D, lat_mode, lat_dir, serial_in);
          cnt <= cnt - AMT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // The bit the next shift would expel follows the direction actually in force.
  assign eff_dir    = (state == IDLE) ? direction : lat_dir;
  assign serial_out = eff_dir ? D[0] : D[N-1];
  assign busy       = (state == SHIFT);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: directed scenarios with literal
// expectations plus randomized traffic against an arithmetic reference model.
module tb_universal_shift_register;

  localparam int N     = 8;
  localparam int AMT_W = 4;
  localparam int MOD   = 1 << N;
  localparam int HALF  = 1 << (N - 1);

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             load      = 1'b0;
  logic [N-1:0]     data_in   = '0;
  logic             start     = 1'b0;
  logic             step      = 1'b0;
  logic [AMT_W-1:0] amount    = '0;
  logic [1:0]       mode      = 2'b00;
  logic             direction = 1'b0;
  logic             serial_in = 1'b0;
  logic [N-1:0]     D;
  logic             serial_out;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  // Reference model state: register value as an integer, shifts still owed,
  // pending done pulse and the controls captured at start.
  int         m_d    = 0;
  int         m_left = 0;
  bit         m_done = 1'b0;
  logic [1:0] m_mode = 2'b00;
  logic       m_dir  = 1'b0;

  always #5 clk = ~clk;

  universal_shift_register #(.N(N), .AMT_W(AMT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .start      (start),
    .step       (step),
    .amount     (amount),
    .mode       (mode),
    .direction  (direction),
    .serial_in  (serial_in),
    .D          (D),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One-position shift written as multiply/divide on an integer.
  function automatic int model_shift(input int x, input logic [1:0] m, input logic dir, input logic sin);
    int r;
    if (m == 2'b10) begin
      r = dir ? (x / 2 + (x % 2) * HALF) : ((x * 2) % MOD + x / HALF);
    end else if (m == 2'b01) begin
      r = dir ? (x / 2 + ((x >= HALF) ? HALF : 0)) : ((x * 2) % MOD);
    end else begin
      r = dir ? (x / 2 + (sin ? HALF : 0)) : ((x * 2) % MOD + (sin ? 1 : 0));
    end
    return r;
  endfunction

  // Model update on every clock edge, cleared asynchronously by reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_d    <= 0;
      m_left <= 0;
      m_done <= 1'b0;
      m_mode <= 2'b00;
      m_dir  <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_d    <= model_shift(m_d, m_mode, m_dir, serial_in);
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (load) begin
      m_d <= int'(data_in);
    end else if (start) begin
      m_mode <= mode;
      m_dir  <= direction;
      if (amount == '0) m_done <= 1'b1;
      else m_left <= int'(amount);
    end else if (step) begin
      m_d <= model_shift(m_d, mode, direction, serial_in);
    end
  end

  // Every cycle, shortly after the edge, compare all outputs with the model.
  initial begin
    logic dir_e;
    forever begin
      @(posedge clk);
      #1;
      dir_e = (m_left > 0 || m_done) ? m_dir : direction;
      check_output("model_D", 32'(D), 32'(m_d));
      check_output("model_busy", 32'(busy), 32'(m_left > 0));
      check_output("model_done", 32'(done), 32'(m_done));
      check_output("model_serial_out", 32'(serial_out), dir_e ? 32'(m_d % 2) : 32'(m_d / HALF));
      check_output("busy_done_exclusive", 32'(busy & done), 32'd0);
    end
  end

  task automatic do_load(input logic [N-1:0] v);
    load    = 1'b1;
    data_in = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Issue a start, optionally hammer load while it runs, and report how many
  // cycles busy was seen, whether done arrived and the value when it did.
  task automatic run_start(input logic [1:0] m, input logic dir, input logic [AMT_W-1:0] a,
                           input logic sin, input bit hold_load,
                           output int busy_cycles, output logic [N-1:0] final_d);
    bit got_done;
    mode        = m;
    direction   = dir;
    amount      = a;
    serial_in   = sin;
    start       = 1'b1;
    busy_cycles = 0;
    got_done    = 1'b0;
    final_d     = '0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (hold_load) begin
        load    = 1'b1;
        data_in = 8'hFF;
      end
      if (busy) busy_cycles++;
      if (done) begin
        got_done = 1'b1;
        final_d  = D;
      end
    end
    check_output("start_done_seen", 32'(got_done), 32'd1);
    load = 1'b0;
    @(negedge clk);
    check_output("done_single_pulse", 32'(done), 32'd0);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int         bc;
    logic [N-1:0] fd;
    logic [3:0] pat;

    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_output("reset_D", 32'(D), 32'h00);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_serial_out", 32'(serial_out), 32'd0);

    do_load(8'hA5);
    run_start(2'b10, 1'b0, 4'd3, 1'b0, 1'b1, bc, fd);
    check_output("rotl_busy_cycles", 32'(bc), 32'd3);
    check_output("rotl_result", 32'(fd), 32'h2D);
    check_output("rotl_load_ignored", 32'(D), 32'h2D);

    do_load(8'h90);
    run_start(2'b01, 1'b1, 4'd2, 1'b0, 1'b0, bc, fd);
    check_output("asr_result", 32'(fd), 32'hE4);
    do_load(8'h90);
    run_start(2'b01, 1'b0, 4'd2, 1'b1, 1'b0, bc, fd);
    check_output("asl_result", 32'(fd), 32'h40);

    do_load(8'h00);
    mode      = 2'b00;
    direction = 1'b0;
    pat       = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step      = 1'b1;
      serial_in = pat[3-i];
      @(negedge clk);
      check_output("step_busy_low", 32'(busy), 32'd0);
    end
    step = 1'b0;
    check_output("step_result", 32'(D), 32'h0A);
    check_output("step_serial_out", 32'(serial_out), 32'd0);

    run_start(2'b00, 1'b0, 4'd0, 1'b0, 1'b0, bc, fd);
    check_output("amt0_busy_cycles", 32'(bc), 32'd0);
    check_output("amt0_unchanged", 32'(fd), 32'h0A);

    do_load(8'h00);
    run_start(2'b00, 1'b1, 4'd9, 1'b1, 1'b0, bc, fd);
    check_output("amt9_busy_cycles", 32'(bc), 32'd9);
    check_output("amt9_result", 32'(fd), 32'hFF);

    do_load(8'h81);
    mode      = 2'b10;
    direction = 1'b0;
    amount    = 4'd5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_output("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_output("abort_D", 32'(D), 32'h00);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    check_output("abort_no_done", 32'(done), 32'd0);
    reset = 1'b1;
    do_load(8'h3C);
    check_output("post_reset_load", 32'(D), 32'h3C);

    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 149) != 0);
      load      = ($urandom_range(0, 9) == 0);
      start     = ($urandom_range(0, 5) == 0);
      step      = ($urandom_range(0, 2) == 0);
      data_in   = N'($urandom);
      amount    = AMT_W'($urandom_range(0, 15));
      mode      = 2'($urandom_range(0, 3));
      direction = 1'($urandom_range(0, 1));
      serial_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    reset = 1'b1;
    load  = 1'b0;
    start = 1'b0;
    step  = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised successor to the single-bit serial shift register. Adds parallel load, logical, arithmetic and rotate modes, and a multi-position shift sequencer with a busy/done handshake. Sits in the lab datapath wherever a shifter must step a word by a programmed amount over successive cycles. It also retains single-step serial streaming for the existing bench-style usage.

## Interface
- N, 8, register width in bits (N >= 2)
- AMT_W, 4, width of the shift-amount field; the largest request is 2^AMT_W-1 positions
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- load  input  1  parallel load of data_in (honoured in IDLE only)
- data_in  input  N  parallel load value
- start  input  1  begin a multi-position shift of `amount` (honoured in IDLE only)
- step  input  1  single one-position shift this cycle (honoured in IDLE only)
- amount  input  AMT_W  number of positions for `start`
- mode  input  2  shift mode: 00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
- direction  input  1  shift direction: 0 = left (toward MSB), 1 = right (toward LSB)
- serial_in  input  1  fill bit for logical mode
- D  output  N  register contents
- serial_out  output  1  bit that the next shift expels: D[N-1] if the effective direction is left, D[0] if right
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse when a `start` request completes

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - Request priority is load > start > step. The lower-priority requests in the same cycle are dropped.
  - load: D <= data_in; stay in IDLE.
  - start: latch mode and direction, set cnt <= amount.
    - amount == 0: go to DONE; D is unchanged.
    - Otherwise go to SHIFT; D is not shifted on the start edge.
  - step: D shifts one position using the live mode, direction and serial_in; stay in IDLE.
- **SHIFT**
  - Every edge: one-position shift using the latched mode and direction, then cnt <= cnt-1.
  - When cnt == 1 at the edge, go to DONE.
  - load, start and step are ignored; no queuing.
- **DONE**: done = 1 for exactly one cycle; next edge returns to IDLE. Requests in this cycle are ignored.
- **Fill rules for a one-position shift**
  - Logical: the vacated bit takes serial_in, sampled live on each shift edge, including inside SHIFT.
  - Arithmetic left: fill 0; serial_in is ignored.
  - Arithmetic right: fill D[N-1] (sign replicate).
  - Rotate: the expelled bit re-enters at the opposite end.
- serial_out is combinational from D and the effective direction:
  - latched direction in SHIFT/DONE;
  - live direction in IDLE.
- An amount of N or more is not clamped; the register simply shifts that many times. In rotate mode this is equivalent to amount mod N.

## Timing
- **Reset (asynchronous, while low)**: D = 0, state = IDLE, cnt = 0, busy = 0, done = 0.
  - Assertion mid-SHIFT aborts immediately; no done pulse is produced.
  - Release: the first edge with reset high is processed normally.
- **start with amount A > 0, accepted on edge k**:
  - busy = 1 after edges k through k+A-1 (A cycles).
  - D shifts on edges k+1 through k+A; the final result is valid after edge k+A.
  - done = 1 for the cycle after edge k+A.
  - IDLE after edge k+A+1, so the next request can be accepted on edge k+A+2.
- **start with amount 0**: done = 1 for the cycle after edge k; busy never rises.
- load and step take effect on the same edge; they add no latency and do not touch busy or done.
- busy and done are never high in the same cycle.

## Test plan
- **Reset values**: hold reset low for 2 cycles, then release -> D = 0x00, busy = 0, done = 0, serial_out = 0.
- **Rotate left**: load 0xA5, then start with mode = 10, direction = 0, amount = 3 -> busy high for exactly 3 cycles, D = 0x2D, then a single done pulse. Assert load = 1 with 0xFF while busy -> ignored, final D is still 0x2D.
- **Arithmetic right**: load 0x90, then start with mode = 01, direction = 1, amount = 2 -> D = 0xE4. Repeat with direction = 0, amount = 2 -> D = 0x40.
- **Logical stepping**: from D = 0x00, step 4 cycles with mode = 00, direction = 0, serial_in = 1, 0, 1, 0 -> D = 0x0A, serial_out = 0, busy stays 0.
- **Amount edge cases**:
  - start with amount = 0 -> done the next cycle, D unchanged.
  - From 0x00, logical right with serial_in = 1 and amount = 9 -> D = 0xFF after 9 shift cycles, one done pulse.
- **Reset mid-operation**: start amount = 5, assert reset after 2 shift edges -> D = 0x00 and busy = 0 immediately, no done pulse. After release, a load of 0x3C succeeds on the first edge.
